// File: rtl/calc_secuenciador.sv
// calc_secuenciador: command-side sequencer for the combinational calculator.
// Accepts a command over valid/ready and registers the operands/opcode toward
// the calculator. It waits LAT settle cycles, captures result and flags, and
// returns them over valid/ready.
// Optional feature macro: CALC_ACC_EN (accumulator as operand A source).
module calc_secuenciador #(
  parameter int N   = 32,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic [3:0]   cmd_op,
  input  logic         cmd_acc,
  output logic [N-1:0] calc_a,
  output logic [N-1:0] calc_b,
  output logic [3:0]   calc_op,
  input  logic [N-1:0] calc_res,
  input  logic [3:0]   calc_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_res,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic         busy
);

  localparam logic [3:0] LAT_C = 4'(LAT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state, state_nx;
  logic [3:0]   cnt;
  logic         op_ok;
  logic         accept;
  logic         issue;
  logic         err_ld;
  logic         capture;
  logic [N-1:0] a_src;

  // Opcodes 0..10 are implemented by the calculator; 11..15 get an error response.
  assign op_ok     = (cmd_op <= 4'd10);
  // Ready is pure registered state, held low while reset is asserted.
  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  // A response is pending exactly while in RESP.
  assign rsp_valid = (state == RESP);

`ifdef CALC_ACC_EN
  logic [N-1:0] acc;

  // Accumulator follows every successful capture; error responses leave it alone.
  always_ff @(posedge clk) begin
    if (rst)          acc <= '0;
    else if (capture) acc <= calc_res;
  end

  assign a_src = cmd_acc ? acc : cmd_a;
`else
  logic unused_acc;
  assign unused_acc = cmd_acc;
  assign a_src      = cmd_a;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    err_ld   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_ok) begin
            issue    = 1'b1;
            state_nx = EXEC;
          end else begin
            err_ld   = 1'b1;
            state_nx = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          capture  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand registers toward the calculator; held between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      calc_a  <= '0;
      calc_b  <= '0;
      calc_op <= '0;
    end else if (issue) begin
      calc_a  <= a_src;
      calc_b  <= cmd_b;
      calc_op <= cmd_op;
    end
  end

  // Settle counter: loaded on issue, counts down to zero while executing.
  always_ff @(posedge clk) begin
    if (rst)                             cnt <= '0;
    else if (issue)                      cnt <= LAT_C;
    else if (state == EXEC && cnt != '0) cnt <= cnt - 4'd1;
  end

  // Response payload: calculator capture or error, held until overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_res   <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else if (capture) begin
      rsp_res   <= calc_res;
      rsp_flags <= calc_flags;
      rsp_err   <= 1'b0;
    end else if (err_ld) begin
      rsp_res   <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b1;
    end
  end

endmodule

// File: doc/calc_secuenciador.md
# calc_secuenciador

Command-side sequencer for the combinational calculator datapath. It accepts operation requests over a valid/ready command channel and drives registered operands and an opcode into the calculator. After a configurable settle latency it captures the calculator's result and flags, then returns them over a valid/ready response channel. It sits between a host/test controller and the calculator, making the calculator usable from pipelined or handshake-driven logic.

## Interface
Parameters:
- N, 32, operand/result width
- LAT, 0, extra settle cycles between operand issue and capture (0–15)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_a  in  N  operand A
- cmd_b  in  N  operand B
- cmd_op  in  4  opcode: 0 suma, 1 resta, 2 mult, 3 div, 4 mod, 5 and, 6 or, 7 xor, 8 shl, 9 shr, 10 mov; 11–15 invalid
- cmd_acc  in  1  use accumulator as operand A (see Configuration)
- calc_a  out  N  operand A to calculator
- calc_b  out  N  operand B to calculator
- calc_op  out  4  opcode to calculator
- calc_res  in  N  calculator result
- calc_flags  in  4  calculator flags (opaque, passed through)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_res  out  N  captured result
- rsp_flags  out  4  captured flags
- rsp_err  out  1  invalid opcode response
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1. Accept on cmd_valid&&cmd_ready at a clock edge.
  - Valid opcode: calc_a/calc_b/calc_op loaded from command; wait counter loaded with LAT; go to EXEC.
  - Invalid opcode (11–15): calc_* unchanged; rsp_res=0, rsp_flags=0, rsp_err=1, rsp_valid=1; go to RESP.
- EXEC: counter nonzero -> decrement. Counter zero -> at the next edge capture calc_res/calc_flags into rsp_res/rsp_flags, set rsp_err=0 and rsp_valid=1, go to RESP.
- RESP: hold all rsp_* stable while rsp_valid&&!rsp_ready. On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE; rsp_res/rsp_flags hold their last values.
- calc_* hold their last issued values between operations. The calculator is therefore never presented a changing operand during EXEC.
- cmd_ready=0 in EXEC and RESP. No command is accepted while a response is pending, so there is no overlap.

## Timing
- Reset (rst high at an edge): state=IDLE; calc_a=0, calc_b=0, calc_op=0; rsp_valid=0, rsp_res=0, rsp_flags=0, rsp_err=0; accumulator=0; busy=0.
- cmd_ready is forced 0 while rst is high and is 1 in the first cycle after release.
- Reset mid-operation drops the in-flight command and any pending response with no output.
- Valid-op latency: rsp_valid rises LAT+1 cycles after the accept edge.
- Invalid-op latency: rsp_valid rises 1 cycle after the accept edge.
- Minimum command period, with rsp_ready held high: LAT+3 cycles. These are the accept, EXEC, and RESP handshake cycles, plus the return to IDLE.
- cmd_ready is registered state only, with no combinational path from rsp_ready.

## Configuration
- CALC_ACC_EN defined: an N-bit accumulator register is updated with rsp_res on every valid-op capture. It is not updated on error responses. When cmd_acc=1 at accept, calc_a is loaded from the accumulator instead of cmd_a.
- CALC_ACC_EN undefined: no accumulator register exists. cmd_acc is ignored and calc_a always comes from cmd_a.

## Test plan
- LAT=0, cmd suma a=5 b=7 -> rsp_valid one cycle after accept, rsp_res=12, rsp_err=0, calc_op=0.
- LAT=3, cmd resta a=3 b=10 -> rsp_valid exactly 4 cycles after accept; rsp_res=0xFFFFFFF9; calc_a/calc_b stable throughout EXEC.
- cmd_op=12 -> rsp_valid next cycle with rsp_err=1, rsp_res=0, rsp_flags=0; calc_* unchanged from prior op.
- Backpressure: rsp_ready low for 5 cycles on a mult 6×7 response -> rsp_res=42 held stable; cmd_ready=0 throughout; second cmd_valid is not accepted until after the response handshake.
- rst asserted in EXEC (LAT=4) -> next cycle all outputs at reset values, no response issued; a new command is accepted after release.
- CALC_ACC_EN: suma 2+3, then cmd_acc=1 suma b=10 -> second rsp_res=15. With the macro undefined, the same sequence with cmd_a=1 gives 11.
